// File: rtl/tl_arb_pkg.sv
// Shared TileLink A-channel arbiter definitions: opcodes, FSM state, beat math.
package tl_arb_pkg;

   localparam logic [2:0] OP_PUT_FULL        = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] OP_GET             = 3'd4;
   localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

   // Enough for size=15 on a 32-bit bus: 2^15/4 = 8192 beats.
   localparam int unsigned BEAT_W = 14;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Beats for a 32-bit data bus: max(1, 2^size/4).
   function automatic logic [BEAT_W-1:0] beats_from_size(input logic [3:0] size);
      logic [BEAT_W-1:0] w_beats;
      if (size <= 4'd2) begin
         w_beats = BEAT_W'(1);
      end else begin
         w_beats = BEAT_W'(1) << (size - 4'd2);
      end
      return w_beats;
   endfunction

endpackage

// File: rtl/tl_arb_rr2.sv
// Two-way pick: locked to the owner during a burst, otherwise priority-pointer
// tie-break among valid, non-blocked requesters.
module tl_arb_rr2 (
   input  logic [1:0] i_valid,
   input  logic [1:0] i_block,
   input  logic       i_prio,
   input  logic       i_lock,
   input  logic       i_owner,
   output logic       o_valid,
   output logic       o_idx
);

   logic [1:0] w_elig;

   assign w_elig = i_valid & ~i_block;

   // Combinational grant; blocking is ignored while locked so a burst completes.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 1'b0;
      if (i_lock) begin
         o_idx   = i_owner;
         o_valid = i_valid[i_owner];
      end else begin
         case (w_elig)
            2'b01:   begin o_valid = 1'b1; o_idx = 1'b0;   end
            2'b10:   begin o_valid = 1'b1; o_idx = 1'b1;   end
            2'b11:   begin o_valid = 1'b1; o_idx = i_prio; end
            default: begin o_valid = 1'b0; o_idx = 1'b0;   end
         endcase
      end
   end

endmodule

// File: rtl/tl_a_arbiter.sv
// Two-requester TileLink-UL A-channel arbiter with D-channel return routing,
// per-requester outstanding limits and a sticky protocol-error flag.
module tl_a_arbiter
   import tl_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned SRC_W   = 6,
   parameter int unsigned MAX_OUT = 8
) (
   input  logic              clock,
   input  logic              reset,
   // requester 0 A
   input  logic              in0_a_valid,
   output logic              in0_a_ready,
   input  logic [2:0]        in0_a_opcode,
   input  logic [2:0]        in0_a_param,
   input  logic [3:0]        in0_a_size,
   input  logic [SRC_W-1:0]  in0_a_source,
   input  logic [ADDR_W-1:0] in0_a_address,
   input  logic [3:0]        in0_a_mask,
   input  logic [31:0]       in0_a_data,
   input  logic              in0_a_corrupt,
   // requester 1 A
   input  logic              in1_a_valid,
   output logic              in1_a_ready,
   input  logic [2:0]        in1_a_opcode,
   input  logic [2:0]        in1_a_param,
   input  logic [3:0]        in1_a_size,
   input  logic [SRC_W-1:0]  in1_a_source,
   input  logic [ADDR_W-1:0] in1_a_address,
   input  logic [3:0]        in1_a_mask,
   input  logic [31:0]       in1_a_data,
   input  logic              in1_a_corrupt,
   // merged A
   output logic              out_a_valid,
   input  logic              out_a_ready,
   output logic [2:0]        out_a_opcode,
   output logic [2:0]        out_a_param,
   output logic [3:0]        out_a_size,
   output logic [SRC_W:0]    out_a_source,
   output logic [ADDR_W-1:0] out_a_address,
   output logic [3:0]        out_a_mask,
   output logic [31:0]       out_a_data,
   output logic              out_a_corrupt,
   // merged D
   input  logic              out_d_valid,
   output logic              out_d_ready,
   input  logic [2:0]        out_d_opcode,
   input  logic [1:0]        out_d_param,
   input  logic [3:0]        out_d_size,
   input  logic [SRC_W:0]    out_d_source,
   input  logic              out_d_sink,
   input  logic              out_d_denied,
   input  logic [31:0]       out_d_data,
   input  logic              out_d_corrupt,
   // requester 0 D
   output logic              in0_d_valid,
   input  logic              in0_d_ready,
   output logic [2:0]        in0_d_opcode,
   output logic [1:0]        in0_d_param,
   output logic [3:0]        in0_d_size,
   output logic [SRC_W-1:0]  in0_d_source,
   output logic              in0_d_sink,
   output logic              in0_d_denied,
   output logic [31:0]       in0_d_data,
   output logic              in0_d_corrupt,
   // requester 1 D
   output logic              in1_d_valid,
   input  logic              in1_d_ready,
   output logic [2:0]        in1_d_opcode,
   output logic [1:0]        in1_d_param,
   output logic [3:0]        in1_d_size,
   output logic [SRC_W-1:0]  in1_d_source,
   output logic              in1_d_sink,
   output logic              in1_d_denied,
   output logic [31:0]       in1_d_data,
   output logic              in1_d_corrupt,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   arb_state_e        r_state;
   logic              r_prio;
   logic              r_owner;
   logic [BEAT_W-1:0] r_remaining;
   logic [2:0]        r_burst_op;
   logic [BEAT_W-1:0] r_d_cnt;
   logic [CNT_W-1:0]  r_cnt0;
   logic [CNT_W-1:0]  r_cnt1;
   logic              r_err;

   logic              w_gvalid;
   logic              w_gidx;
   logic [1:0]        w_block;
   logic              w_a_fire;
   logic              w_a_first;
   logic [BEAT_W-1:0] w_a_beats;
   logic              w_d_sel;
   logic              w_d_fire;
   logic              w_d_last;
   logic [BEAT_W-1:0] w_d_beats;
   logic              w_inc0, w_inc1, w_dec0, w_dec1;

   assign w_block = {r_cnt1 == CNT_W'(MAX_OUT), r_cnt0 == CNT_W'(MAX_OUT)};

   tl_arb_rr2 u_rr2 (
      .i_valid ({in1_a_valid, in0_a_valid}),
      .i_block (w_block),
      .i_prio  (r_prio),
      .i_lock  (r_state == ST_BURST),
      .i_owner (r_owner),
      .o_valid (w_gvalid),
      .o_idx   (w_gidx)
   );

   // A-channel mux and handshake; valid/ready are forced low while in reset.
   always_comb begin
      out_a_opcode  = w_gidx ? in1_a_opcode  : in0_a_opcode;
      out_a_param   = w_gidx ? in1_a_param   : in0_a_param;
      out_a_size    = w_gidx ? in1_a_size    : in0_a_size;
      out_a_source  = {w_gidx, (w_gidx ? in1_a_source : in0_a_source)};
      out_a_address = w_gidx ? in1_a_address : in0_a_address;
      out_a_mask    = w_gidx ? in1_a_mask    : in0_a_mask;
      out_a_data    = w_gidx ? in1_a_data    : in0_a_data;
      out_a_corrupt = w_gidx ? in1_a_corrupt : in0_a_corrupt;
      out_a_valid   = reset & w_gvalid;
      in0_a_ready   = reset & out_a_ready & w_gvalid & ~w_gidx;
      in1_a_ready   = reset & out_a_ready & w_gvalid &  w_gidx;
      w_a_fire      = out_a_valid & out_a_ready;
      w_a_first     = w_a_fire & (r_state == ST_IDLE);
      if (out_a_opcode == OP_PUT_FULL || out_a_opcode == OP_PUT_PARTIAL) begin
         w_a_beats = beats_from_size(out_a_size);
      end else begin
         w_a_beats = BEAT_W'(1);
      end
   end

   // D-channel routing by the top source bit, with last-beat detection.
   always_comb begin
      w_d_sel      = out_d_source[SRC_W];
      in0_d_valid  = reset & out_d_valid & ~w_d_sel;
      in1_d_valid  = reset & out_d_valid &  w_d_sel;
      out_d_ready  = reset & (w_d_sel ? in1_d_ready : in0_d_ready);
      in0_d_opcode = out_d_opcode;
      in1_d_opcode = out_d_opcode;
      in0_d_param  = out_d_param;
      in1_d_param  = out_d_param;
      in0_d_size   = out_d_size;
      in1_d_size   = out_d_size;
      in0_d_source = out_d_source[SRC_W-1:0];
      in1_d_source = out_d_source[SRC_W-1:0];
      in0_d_sink   = out_d_sink;
      in1_d_sink   = out_d_sink;
      in0_d_denied = out_d_denied;
      in1_d_denied = out_d_denied;
      in0_d_data   = out_d_data;
      in1_d_data   = out_d_data;
      in0_d_corrupt = out_d_corrupt;
      in1_d_corrupt = out_d_corrupt;
      w_d_fire     = out_d_valid & out_d_ready;
      if (out_d_opcode == OP_ACCESS_ACK_DATA) begin
         w_d_beats = beats_from_size(out_d_size);
      end else begin
         w_d_beats = BEAT_W'(1);
      end
      w_d_last = w_d_fire & (r_d_cnt == w_d_beats - BEAT_W'(1));
      w_inc0   = w_a_first & ~w_gidx;
      w_inc1   = w_a_first &  w_gidx;
      w_dec0   = w_d_last  & ~w_d_sel;
      w_dec1   = w_d_last  &  w_d_sel;
   end

   assign err = r_err;

   // Arbitration FSM: burst lock, remaining-beat count and priority pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_prio      <= 1'b0;
         r_owner     <= 1'b0;
         r_remaining <= '0;
         r_burst_op  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_a_fire) begin
                  r_prio <= ~w_gidx;
                  if (w_a_beats > BEAT_W'(1)) begin
                     r_state     <= ST_BURST;
                     r_owner     <= w_gidx;
                     r_remaining <= w_a_beats - BEAT_W'(1);
                     r_burst_op  <= out_a_opcode;
                  end
               end
            end
            ST_BURST: begin
               if (w_a_fire) begin
                  r_remaining <= r_remaining - BEAT_W'(1);
                  if (r_remaining == BEAT_W'(1)) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // D beat position within the current response message.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_d_cnt <= '0;
      end else if (w_d_fire) begin
         r_d_cnt <= w_d_last ? '0 : r_d_cnt + BEAT_W'(1);
      end
   end

   // Outstanding counters; simultaneous inc/dec cancels, underflow holds at 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_inc0 && !w_dec0) begin
            r_cnt0 <= r_cnt0 + CNT_W'(1);
         end else if (w_dec0 && !w_inc0 && r_cnt0 != '0) begin
            r_cnt0 <= r_cnt0 - CNT_W'(1);
         end
         if (w_inc1 && !w_dec1) begin
            r_cnt1 <= r_cnt1 + CNT_W'(1);
         end else if (w_dec1 && !w_inc1 && r_cnt1 != '0) begin
            r_cnt1 <= r_cnt1 - CNT_W'(1);
         end
      end
   end

   // Sticky protocol-violation flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if ((w_a_first && out_a_size > 4'd6) ||
                   (w_dec0 && r_cnt0 == '0) ||
                   (w_dec1 && r_cnt1 == '0) ||
                   (w_a_fire && r_state == ST_BURST && out_a_opcode != r_burst_op)) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Self-checking bench for tl_a_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_tl_a_arbiter;

   localparam int ADDR_W  = 14;
   localparam int SRC_W   = 6;
   localparam int MAX_OUT = 8;

   logic clock, reset;
   logic in0_a_valid, in0_a_ready, in0_a_corrupt;
   logic [2:0] in0_a_opcode, in0_a_param;
   logic [3:0] in0_a_size, in0_a_mask;
   logic [SRC_W-1:0] in0_a_source;
   logic [ADDR_W-1:0] in0_a_address;
   logic [31:0] in0_a_data;
   logic in1_a_valid, in1_a_ready, in1_a_corrupt;
   logic [2:0] in1_a_opcode, in1_a_param;
   logic [3:0] in1_a_size, in1_a_mask;
   logic [SRC_W-1:0] in1_a_source;
   logic [ADDR_W-1:0] in1_a_address;
   logic [31:0] in1_a_data;
   logic out_a_valid, out_a_ready, out_a_corrupt;
   logic [2:0] out_a_opcode, out_a_param;
   logic [3:0] out_a_size, out_a_mask;
   logic [SRC_W:0] out_a_source;
   logic [ADDR_W-1:0] out_a_address;
   logic [31:0] out_a_data;
   logic out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
   logic [2:0] out_d_opcode;
   logic [1:0] out_d_param;
   logic [3:0] out_d_size;
   logic [SRC_W:0] out_d_source;
   logic [31:0] out_d_data;
   logic in0_d_valid, in0_d_ready, in0_d_sink, in0_d_denied, in0_d_corrupt;
   logic [2:0] in0_d_opcode;
   logic [1:0] in0_d_param;
   logic [3:0] in0_d_size;
   logic [SRC_W-1:0] in0_d_source;
   logic [31:0] in0_d_data;
   logic in1_d_valid, in1_d_ready, in1_d_sink, in1_d_denied, in1_d_corrupt;
   logic [2:0] in1_d_opcode;
   logic [1:0] in1_d_param;
   logic [3:0] in1_d_size;
   logic [SRC_W-1:0] in1_d_source;
   logic [31:0] in1_d_data;
   logic err;

   int checks = 0;
   int errors = 0;

   tl_a_arbiter #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
      .clock(clock), .reset(reset),
      .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
      .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
      .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
      .in0_a_corrupt(in0_a_corrupt),
      .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
      .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
      .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
      .in1_a_corrupt(in1_a_corrupt),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
      .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
      .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
      .out_a_corrupt(out_a_corrupt),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
      .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
      .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
      .out_d_corrupt(out_d_corrupt),
      .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
      .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
      .in0_d_sink(in0_d_sink), .in0_d_denied(in0_d_denied), .in0_d_data(in0_d_data),
      .in0_d_corrupt(in0_d_corrupt),
      .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
      .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
      .in1_d_sink(in1_d_sink), .in1_d_denied(in1_d_denied), .in1_d_data(in1_d_data),
      .in1_d_corrupt(in1_d_corrupt),
      .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Transfer size in beats on a 32-bit bus, from the protocol rule.
   function automatic int ref_beats(input int op, input int sz);
      int b;
      if (op != 0 && op != 1) return 1;
      b = (1 << sz) / 4;
      return (b < 1) ? 1 : b;
   endfunction

   task automatic set_a0(input logic v, input int op, input int sz, input int src,
                         input int addr, input int data);
      in0_a_valid = v; in0_a_opcode = 3'(op); in0_a_size = 4'(sz);
      in0_a_source = 6'(src); in0_a_address = 14'(addr); in0_a_data = 32'(data);
      in0_a_param = '0; in0_a_mask = 4'hF; in0_a_corrupt = 1'b0;
   endtask

   task automatic set_a1(input logic v, input int op, input int sz, input int src,
                         input int addr, input int data);
      in1_a_valid = v; in1_a_opcode = 3'(op); in1_a_size = 4'(sz);
      in1_a_source = 6'(src); in1_a_address = 14'(addr); in1_a_data = 32'(data);
      in1_a_param = '0; in1_a_mask = 4'hF; in1_a_corrupt = 1'b0;
   endtask

   task automatic set_d(input logic v, input int op, input int sz, input int src,
                        input int data);
      out_d_valid = v; out_d_opcode = 3'(op); out_d_size = 4'(sz);
      out_d_source = 7'(src); out_d_data = 32'(data);
      out_d_param = '0; out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_corrupt = 1'b0;
   endtask

   task automatic idle_inputs();
      set_a0(1'b0, 4, 2, 0, 0, 0);
      set_a1(1'b0, 4, 2, 0, 0, 0);
      set_d(1'b0, 0, 2, 0, 0);
      out_a_ready = 1'b0; in0_d_ready = 1'b0; in1_d_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b0;
      set_a0(1'b1, 4, 2, 5, 14'h1234, 32'hA5A5_0001);
      set_d(1'b1, 1, 2, 3, 32'hDEAD_BEEF);
      out_a_ready = 1'b1; in0_d_ready = 1'b1;
      #1;
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b want 0", out_a_valid); end
      checks++; if (in0_a_ready !== 1'b0) begin errors++; $display("FAIL rst_in0_a_ready got %b want 0", in0_a_ready); end
      checks++; if (in0_d_valid !== 1'b0) begin errors++; $display("FAIL rst_in0_d_valid got %b want 0", in0_d_valid); end
      checks++; if (out_d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %b want 0", out_d_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
      checks++; if (out_a_address !== 14'h1234) begin errors++; $display("FAIL rst_a_addr got %h want 1234", out_a_address); end
      checks++; if (in0_d_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_d_data got %h want deadbeef", in0_d_data); end
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_arbitration();
      do_reset();
      @(negedge clock);
      set_a0(1'b1, 4, 2, 6'h11, 100, 0);
      set_a1(1'b1, 4, 2, 6'h22, 200, 0);
      out_a_ready = 1'b1;
      #1;
      checks++; if (out_a_source !== 7'h11 || in0_a_ready !== 1'b1 || in1_a_ready !== 1'b0) begin
         errors++; $display("FAIL arb_cycle0 src=%h r0=%b r1=%b want src=11 r0=1 r1=0", out_a_source, in0_a_ready, in1_a_ready); end
      @(negedge clock);
      #1;
      checks++; if (out_a_source !== 7'h62 || in0_a_ready !== 1'b0 || in1_a_ready !== 1'b1) begin
         errors++; $display("FAIL arb_cycle1 src=%h r0=%b r1=%b want src=62 r0=0 r1=1", out_a_source, in0_a_ready, in1_a_ready); end
      checks++; if (out_a_address !== 14'd200 || out_a_size !== 4'd2) begin
         errors++; $display("FAIL arb_fields addr=%0d size=%0d want 200/2", out_a_address, out_a_size); end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_burst();
      do_reset();
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         set_a0(1'b1, 0, 4, 6'h01, 40, 32'hB000 + b);
         set_a1(1'b1, 4, 2, 6'h02, 80, 0);
         out_a_ready = 1'b1;
         #1;
         checks++; if (out_a_source !== 7'h01 || out_a_data !== 32'hB000 + b || in1_a_ready !== 1'b0 || in0_a_ready !== 1'b1) begin
            errors++; $display("FAIL burst_beat%0d src=%h data=%h r1=%b r0=%b want src=01 data=%h r1=0 r0=1",
                               b, out_a_source, out_a_data, in1_a_ready, in0_a_ready, 32'hB000 + b); end
      end
      @(negedge clock);
      set_a0(1'b0, 4, 2, 0, 0, 0);
      #1;
      checks++; if (out_a_source !== 7'h42 || in1_a_ready !== 1'b1 || out_a_opcode !== 3'd4) begin
         errors++; $display("FAIL burst_then_get src=%h r1=%b op=%0d want 42/1/4", out_a_source, in1_a_ready, out_a_opcode); end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_block();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         set_a0(1'b1, 4, 2, i, i, 0);
         out_a_ready = 1'b1;
         #1;
         checks++; if (in0_a_ready !== 1'b1) begin errors++; $display("FAIL block_get%0d ready got %b want 1", i, in0_a_ready); end
      end
      @(negedge clock);
      set_a0(1'b1, 4, 2, 8, 8, 0);
      set_a1(1'b1, 4, 2, 9, 9, 0);
      set_d(1'b1, 0, 2, 7'h05, 0);
      in0_d_ready = 1'b1;
      #1;
      checks++; if (in0_a_ready !== 1'b0 || in1_a_ready !== 1'b1 || out_a_source !== 7'h49) begin
         errors++; $display("FAIL block_stall r0=%b r1=%b src=%h want 0/1/49", in0_a_ready, in1_a_ready, out_a_source); end
      checks++; if (in0_d_valid !== 1'b1 || in1_d_valid !== 1'b0 || in0_d_source !== 6'h05 || out_d_ready !== 1'b1) begin
         errors++; $display("FAIL block_d v0=%b v1=%b src=%h rdy=%b want 1/0/05/1", in0_d_valid, in1_d_valid, in0_d_source, out_d_ready); end
      @(negedge clock);
      set_a1(1'b0, 4, 2, 0, 0, 0);
      set_d(1'b0, 0, 2, 0, 0);
      #1;
      checks++; if (in0_a_ready !== 1'b1 || out_a_source !== 7'h08) begin
         errors++; $display("FAIL block_release r0=%b src=%h want 1/08", in0_a_ready, out_a_source); end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_d_route();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         set_a1(1'b1, 4, 2, 3, i, 0);
         out_a_ready = 1'b1;
         #1;
      end
      // beat 2 is first offered with in1_d_ready low to exercise backpressure
      for (int s = 0; s < 5; s++) begin
         @(negedge clock);
         set_d(1'b1, 1, 4, 7'h43, 32'hD000 + ((s < 2) ? s : s - 1));
         in1_d_ready = (s != 1);
         #1;
         checks++; if (in1_d_valid !== 1'b1 || in0_d_valid !== 1'b0 || in1_d_source !== 6'h03 ||
                       out_d_ready !== (s != 1) || in1_a_ready !== 1'b0) begin
            errors++; $display("FAIL droute_step%0d v1=%b v0=%b src=%h rdy=%b a_r1=%b want 1/0/03/%b/0",
                               s, in1_d_valid, in0_d_valid, in1_d_source, out_d_ready, in1_a_ready, (s != 1)); end
      end
      @(negedge clock);
      set_d(1'b0, 0, 2, 0, 0);
      #1;
      checks++; if (in1_a_ready !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL droute_unblock a_r1=%b err=%b want 1/0", in1_a_ready, err); end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int b = 0; b < 2; b++) begin
         @(negedge clock);
         set_a0(1'b1, 0, 4, 1, 0, b);
         set_a1(1'b1, 4, 2, 2, 0, 0);
         out_a_ready = 1'b1;
         #1;
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if (out_a_valid !== 1'b0 || in0_a_ready !== 1'b0 || in1_a_ready !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL midrst_outs v=%b r0=%b r1=%b err=%b want 0/0/0/0", out_a_valid, in0_a_ready, in1_a_ready, err); end
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      set_a0(1'b1, 4, 2, 1, 0, 0);
      set_a1(1'b1, 4, 2, 2, 0, 0);
      out_a_ready = 1'b1;
      #1;
      checks++; if (out_a_source !== 7'h01 || in0_a_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_first src=%h r0=%b want 01/1", out_a_source, in0_a_ready); end
      @(negedge clock);
      #1;
      checks++; if (out_a_source !== 7'h42 || in1_a_ready !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL midrst_second src=%h r1=%b err=%b want 42/1/0", out_a_source, in1_a_ready, err); end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_random();
      int act[2], op[2], sz[2], left[2], src[2], addr[2];
      logic v[2];
      int m_cnt[2];
      int m_prio, m_burst, m_owner, m_left;
      int gv, gi, a_rdy, dv, dr0, dr1, r, exp_src;
      do_reset();
      m_cnt[0] = 0; m_cnt[1] = 0; m_prio = 0; m_burst = 0; m_owner = 0; m_left = 0;
      act[0] = 0; act[1] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         for (int n = 0; n < 2; n++) begin
            if (act[n] == 0 && $urandom_range(1, 0) == 1) begin
               act[n] = 1;
               case ($urandom_range(2, 0))
                  0: op[n] = 0;
                  1: op[n] = 1;
                  default: op[n] = 4;
               endcase
               sz[n] = $urandom_range(6, 0);
               left[n] = ref_beats(op[n], sz[n]);
               src[n] = $urandom_range(63, 0);
               addr[n] = $urandom_range(16383, 0);
            end
            v[n] = (act[n] != 0) && ($urandom_range(3, 0) != 0);
         end
         set_a0(v[0], op[0], sz[0], src[0], addr[0], cyc);
         set_a1(v[1], op[1], sz[1], src[1], addr[1], cyc);
         a_rdy = ($urandom_range(3, 0) != 0);
         out_a_ready = a_rdy[0];
         r = $urandom_range(1, 0);
         dv = (m_cnt[r] > 0) && ($urandom_range(1, 0) == 1);
         dr0 = $urandom_range(1, 0);
         dr1 = $urandom_range(1, 0);
         set_d(dv[0], 0, $urandom_range(6, 0), r * 64 + $urandom_range(63, 0), cyc);
         in0_d_ready = dr0[0];
         in1_d_ready = dr1[0];
         #1;
         if (m_burst != 0) begin
            gi = m_owner;
            gv = v[gi];
         end else begin
            gv = 0; gi = 0;
            if (v[0] && m_cnt[0] < MAX_OUT) begin gv = 1; gi = 0; end
            if (v[1] && m_cnt[1] < MAX_OUT) begin
               if (gv != 0) gi = m_prio;
               else gi = 1;
               gv = 1;
            end
         end
         exp_src = gi * 64 + src[gi];
         checks++; if (out_a_valid !== gv[0] || in0_a_ready !== (gv != 0 && gi == 0 && a_rdy != 0) ||
                       in1_a_ready !== (gv != 0 && gi == 1 && a_rdy != 0)) begin
            errors++; $display("FAIL rand_a_hs cyc%0d v=%b r0=%b r1=%b want gv=%0d gi=%0d rdy=%0d",
                               cyc, out_a_valid, in0_a_ready, in1_a_ready, gv, gi, a_rdy); end
         if (gv != 0) begin
            checks++; if (int'(out_a_source) != exp_src || int'(out_a_address) != addr[gi]) begin
               errors++; $display("FAIL rand_a_fields cyc%0d src=%h addr=%0d want src=%h addr=%0d",
                                  cyc, out_a_source, out_a_address, exp_src, addr[gi]); end
         end
         checks++; if (in0_d_valid !== (dv != 0 && r == 0) || in1_d_valid !== (dv != 0 && r == 1) ||
                       out_d_ready !== ((r == 1) ? dr1[0] : dr0[0]) || err !== 1'b0) begin
            errors++; $display("FAIL rand_d cyc%0d v0=%b v1=%b rdy=%b err=%b want dv=%0d r=%0d", cyc,
                               in0_d_valid, in1_d_valid, out_d_ready, err, dv, r); end
         if (gv != 0 && a_rdy != 0) begin
            if (m_burst == 0) begin
               m_cnt[gi]++;
               m_prio = 1 - gi;
               if (ref_beats(op[gi], sz[gi]) > 1) begin
                  m_burst = 1; m_owner = gi; m_left = ref_beats(op[gi], sz[gi]) - 1;
               end
            end else begin
               m_left--;
               if (m_left == 0) m_burst = 0;
            end
            left[gi]--;
            if (left[gi] == 0) act[gi] = 0;
         end
         if (dv != 0 && ((r == 1) ? dr1 : dr0) != 0) m_cnt[r]--;
      end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_err();
      // oversize first beat
      do_reset();
      @(negedge clock);
      set_a0(1'b1, 4, 7, 1, 0, 0);
      out_a_ready = 1'b1;
      @(negedge clock);
      set_a0(1'b0, 4, 2, 0, 0, 0);
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_size7 got %b want 1", err); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         set_a1(1'b1, 4, 2, i, i, 0);
         set_d(1'b1, 0, 2, 7'h01, 0);
         in0_d_ready = (i == 0);
         #1;
      end
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
      @(negedge clock);
      reset = 1'b1;
      // D completion with nothing outstanding
      @(negedge clock);
      set_d(1'b1, 0, 2, 7'h40, 0);
      in1_d_ready = 1'b1;
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_underflow got %b want 1", err); end
      // opcode change inside a burst
      do_reset();
      @(negedge clock);
      set_a0(1'b1, 0, 3, 1, 0, 0);
      out_a_ready = 1'b1;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pre_burst got %b want 0", err); end
      @(negedge clock);
      set_a0(1'b1, 1, 3, 1, 0, 0);
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_opcode_change got %b want 1", err); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_arbitration();
      test_burst();
      test_block();
      test_d_route();
      test_reset_mid_burst();
      test_random();
      test_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
